// File: rtl/j1_io_pkg.sv
// Shared definitions for J1 I/O-bus peripherals: register offsets, STATUS bit
// positions and the serial framing state type used by the UART TX/RX engines.
package j1_io_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_RX_VALID     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_IDLE      = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_RX_FRAME_ERR = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/j1_uart.sv
// Memory-mapped 8N1 UART for the J1 I/O bus: buffered transmitter, single-byte
// receive holding register with sticky error flags, zero-latency reads.
module j1_uart
  import j1_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter int          TX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o,
  output logic        rx_irq_o
);
  logic        sel, rd_data, rd_status, wr_data, wr_div;
  logic        unused_addr_bit;
  logic [15:0] div_q, div_d;

  logic        fifo_full, fifo_empty, tx_pop, tx_load;
  logic [7:0]  fifo_data;
  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic        rx_deliver, rx_ferr_set;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

  assign unused_addr_bit = io_addr[0];
  assign sel       = (io_addr[15:3] == BASE_ADDR[15:3]);
  assign rd_data   = io_rd && sel && (io_addr[2:1] == REG_DATA);
  assign rd_status = io_rd && sel && (io_addr[2:1] == REG_STATUS);
  assign wr_data   = io_wr && sel && (io_addr[2:1] == REG_DATA);
  assign wr_div    = io_wr && sel && (io_addr[2:1] == REG_DIV);

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (sys_clk_i),
    .rst_n_i (sys_rst_n_i),
    .push_i  (wr_data),
    .data_i  (io_dout[7:0]),
    .pop_i   (tx_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    case (tx_state_q)
      IDLE:  tx_load = !fifo_empty;
      START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = DATA;
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (fifo_empty) tx_state_d = IDLE;
          else            tx_load    = 1'b1;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = IDLE;
    endcase
    // Frame start: divisor is frozen here for the whole frame.
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_state_d = START;
      tx_shift_d = fifo_data;
      tx_div_d   = div_q;
      tx_cnt_d   = div_q - 16'd1;
      txd_d      = 1'b0;
    end
  end

  // The edge detector needs s3=1, so after a bad stop bit the line must go high first.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_deliver  = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = START;
          rx_div_d   = div_q;
          rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
        end
      end
      START: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = rx_s2_q ? IDLE : DATA;
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = 3'd0;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d  = IDLE;
          rx_deliver  = rx_s2_q;
          rx_ferr_set = !rx_s2_q;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Set beats clear-on-read for every flag and for rx_valid.
  always_comb begin
    rx_data_d  = rx_deliver ? rx_shift_q : rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rd_data)    rx_valid_d = 1'b0;
    if (rx_deliver) rx_valid_d = 1'b1;
    rx_ovr_d = rx_ovr_q;
    if (rd_status) rx_ovr_d = 1'b0;
    if (rx_deliver && rx_valid_q && !rd_data) rx_ovr_d = 1'b1;
    rx_ferr_d = rx_ferr_q;
    if (rd_status)   rx_ferr_d = 1'b0;
    if (rx_ferr_set) rx_ferr_d = 1'b1;
    div_d = div_q;
    if (wr_div) div_d = (io_dout < 16'd2) ? 16'd2 : io_dout;
  end

  always_comb begin
    io_din = 16'h0000;
    if (io_rd && sel) begin
      case (io_addr[2:1])
        REG_DATA:   io_din = {8'h00, rx_data_q};
        REG_STATUS: begin
          io_din[ST_RX_VALID]     = rx_valid_q;
          io_din[ST_TX_FULL]      = fifo_full;
          io_din[ST_TX_IDLE]      = fifo_empty && (tx_state_q == IDLE);
          io_din[ST_RX_OVERRUN]   = rx_ovr_q;
          io_din[ST_RX_FRAME_ERR] = rx_ferr_q;
        end
        REG_DIV:    io_din = div_q;
        default:    io_din = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      div_q      <= DEFAULT_DIV;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_s1_q    <= uart_rxd_i;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign uart_txd_o = txd_q;
  assign rx_irq_o   = rx_valid_q;

endmodule

// File: tb/tb_j1_uart.sv
// Bench for j1_uart: bus reads and serial TX frames are checked by monitors
// against expected queues filled by the directed stimulus.
module tb_j1_uart;

  localparam logic [15:0] A_DATA = 16'h4000;
  localparam logic [15:0] A_STAT = 16'h4002;
  localparam logic [15:0] A_DIV  = 16'h4004;
  localparam logic [15:0] A_R3   = 16'h4006;
  localparam int          RX_DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_dout = 16'h0000;
  logic [15:0] io_din;
  logic        rxd = 1'b1;
  logic        txd;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [15:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  int          tx_div = 4;
  bit          tx_mon_en = 1'b1;

  always #5 clk = ~clk;

  j1_uart dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .io_rd       (io_rd),
    .io_wr       (io_wr),
    .io_addr     (io_addr),
    .io_dout     (io_dout),
    .io_din      (io_din),
    .uart_rxd_i  (rxd),
    .uart_txd_o  (txd),
    .rx_irq_o    (irq)
  );

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1; io_addr = a; io_dout = d;
    @(posedge clk); #1;
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string n);
    rd_exp_q.push_back(e);
    rd_name_q.push_back(n);
    io_rd = 1'b1; io_addr = a;
    @(posedge clk); #1;
    io_rd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (RX_DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (RX_DIV) @(posedge clk);
      #1;
    end
    rxd = stop_bit;
    repeat (RX_DIV) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // ---------------- scoreboard: bus read monitor ----------------
  always @(negedge clk) begin : rd_mon
    logic [15:0] e;
    string n;
    if (io_rd === 1'b1) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%04h", io_din);
      end else begin
        e = rd_exp_q.pop_front();
        n = rd_name_q.pop_front();
        if (io_din !== e) begin
          failures++;
          $display("FAIL %s got=%04h exp=%04h", n, io_din, e);
        end
      end
    end
  end

  // ---------------- scoreboard: serial TX monitor, clock-exact ----------------
  initial begin : tx_mon
    logic [7:0] e, got;
    logic       expbit;
    int         bad, k;
    bit         have, aborted;
    forever begin
      @(negedge clk);
      if (tx_mon_en && rst_n && txd === 1'b0) begin
        have = (tx_exp_q.size() != 0);
        e = have ? tx_exp_q.pop_front() : 8'h00;
        bad = 0; got = 8'h00; aborted = 1'b0;
        for (int c = 1; c < 10 * tx_div; c++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          k = c / tx_div;
          if (k == 0)      expbit = 1'b0;
          else if (k == 9) expbit = 1'b1;
          else             expbit = e[k-1];
          if (txd !== expbit) bad++;
          if (k >= 1 && k <= 8 && (c % tx_div) == tx_div / 2) got[k-1] = txd;
        end
        if (!aborted) begin
          checks++;
          if (!have) begin
            failures++;
            $display("FAIL tx_extra_frame got=%02h exp=none", got);
          end else if (bad != 0 || got !== e) begin
            failures++;
            $display("FAIL tx_frame got=%02h exp=%02h bad_clocks=%0d", got, e, bad);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_txd", txd, 1);
    chk("rst_irq", irq, 0);
    rd(A_STAT, 16'h0004, "rst_status");
    rd(A_DIV, 16'd434, "rst_div");

    wr(A_DIV, 16'h0001);
    rd(A_DIV, 16'h0002, "div_clamp_1");
    wr(A_DIV, 16'h0000);
    rd(A_DIV, 16'h0002, "div_clamp_0");
    wr(A_DIV, 16'h0004);
    rd(A_DIV, 16'h0004, "div_4");

    // Single frame 0x55, start bit one cycle after the pop cycle
    tx_exp_q.push_back(8'h55);
    wr(A_DATA, 16'h0055);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd !== 1'b0 && n < 20);
    chk("tx_start_latency", n, 2);
    @(posedge clk); #1;
    rd(A_STAT, 16'h0000, "status_tx_busy");
    repeat (50) @(posedge clk);
    #1;
    rd(A_STAT, 16'h0004, "status_idle_after_tx");

    // 18 back-to-back writes: 17 fit (one popped + 16 stored), the 18th is lost
    for (int i = 0; i < 18; i++) begin
      if (i < 17) tx_exp_q.push_back(i[7:0]);
      io_wr = 1'b1; io_addr = A_DATA; io_dout = i[15:0];
      @(posedge clk); #1;
    end
    io_wr = 1'b0;
    rd(A_STAT, 16'h0002, "status_tx_full");
    repeat (17 * 40 + 40) @(posedge clk);
    #1;
    chk("tx_all_frames_seen", tx_exp_q.size(), 0);
    rd(A_STAT, 16'h0004, "status_idle_after_burst");

    // RX single byte
    wr(A_DIV, RX_DIV[15:0]);
    send_rx(8'hA5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rx_irq_set", irq, 1);
    rd(A_STAT, 16'h0005, "rx_status_valid");
    rd(A_DATA, 16'h00A5, "rx_data_a5");
    rd(A_STAT, 16'h0004, "rx_status_popped");
    chk("rx_irq_clear", irq, 0);

    // Overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rd(A_DATA, 16'h0022, "rx_overrun_data");
    rd(A_STAT, 16'h000C, "rx_overrun_flag");
    rd(A_STAT, 16'h0004, "rx_overrun_cleared");

    // Frame error keeps the held byte
    send_rx(8'h3C, 1'b1);
    send_rx(8'h5A, 1'b0);
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd(A_STAT, 16'h0015, "rx_frame_err_status");
    rd(A_STAT, 16'h0005, "rx_frame_err_cleared");
    rd(A_DATA, 16'h003C, "rx_data_kept");

    // One-clock glitch on idle line
    rxd = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rd(A_STAT, 16'h0004, "rx_glitch_ignored");

    // Reset in the middle of a TX frame of zeros
    tx_mon_en = 1'b0;
    wr(A_DIV, 16'h0004);
    wr(A_DATA, 16'h0000);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_txd_low", txd, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_txd_async", txd, 1);
    chk("rst_irq_async", irq, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tx_mon_en = 1'b1;
    chk("post_rst_txd", txd, 1);
    rd(A_STAT, 16'h0004, "post_rst_status");
    rd(A_DIV, 16'd434, "post_rst_div");
    rd(16'h4008, 16'h0000, "unselected_above");
    rd(16'h3FFA, 16'h0000, "unselected_below");
    rd(A_R3, 16'h0000, "reg3_read");
    wr(A_R3, 16'hFFFF);
    rd(A_DIV, 16'd434, "reg3_write_ignored");
    rd(16'h4003, 16'h0004, "addr_bit0_ignored");

    repeat (5) @(posedge clk);
    #1;
    chk("rd_queue_drained", rd_exp_q.size(), 0);
    chk("tx_queue_drained", tx_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/j1_uart.md
Name: j1_uart

Overview:
- Memory-mapped UART peripheral on the J1 I/O bus, downstream of the CPU core.
- Consumes io_rd/io_wr/io_addr/io_dout and returns io_din combinationally in the same cycle, because the CPU's `@` instruction samples io_din in the cycle it asserts io_rd.
- Provides a buffered 8N1 transmitter (TX FIFO) and a single-byte receive holding register with error flags.
- io_din is 0 when not addressed, so several peripherals can be OR-combined onto the CPU's io_din.

Parameters:
- BASE_ADDR, 16'h4000, byte address of the DATA register; must be 8-byte aligned and lie in I/O space (bits [15:14] != 0).
- TX_DEPTH, 16, TX FIFO entries; power of two, >= 2.
- DEFAULT_DIV, 16'd434, clocks per bit after reset (50 MHz / 115200).

Ports:
- sys_clk_i  input  1  system clock
- sys_rst_n_i  input  1  asynchronous reset, active-low
- io_rd  input  1  CPU I/O read strobe, one cycle per access
- io_wr  input  1  CPU I/O write strobe, one cycle per access
- io_addr  input  16  CPU I/O byte address
- io_dout  input  16  CPU write data
- io_din  output  16  read data; combinational from io_rd/io_addr and state; 0 when not selected
- uart_rxd_i  input  1  serial receive line, asynchronous
- uart_txd_o  output  1  serial transmit line, idle high
- rx_irq_o  output  1  level high while rx_valid

Behaviour:
- Register map: a register is selected when io_addr[15:3] == BASE_ADDR[15:3]; io_addr[2:1] picks the register; io_addr[0] is ignored.
  - 0 DATA: write pushes io_dout[7:0] into the TX FIFO; read returns {8'h00, rx_data} and pops (clears rx_valid) at the clock edge.
  - 1 STATUS (read-only): bit0 rx_valid, bit1 tx_full, bit2 tx_idle (FIFO empty and TX FSM IDLE), bit3 rx_overrun, bit4 rx_frame_err; other bits 0. A read clears bits 3 and 4 at the edge.
  - 2 DIVISOR: read/write 16 bits; written values < 2 are stored as 2.
  - 3: reads 0; writes ignored.
- Writes and side effects are registered on the posedge when the strobe is high and the address is selected. Reads have zero latency. Unselected reads return 16'h0000 and have no side effects.
- Reset (asynchronous assert, synchronous use after deassert):
  - uart_txd_o=1; FIFO empty; TX/RX FSMs IDLE; rx_valid=0; flags=0; divisor=DEFAULT_DIV; rx_irq_o=0.
  - Reset mid-frame aborts the frame immediately and drives the line high.
- TX FIFO:
  - A push while full is dropped silently and the FIFO is unchanged.
  - A push and a TX pop in the same cycle are both honoured, including when full.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Leaves IDLE when the FIFO is non-empty: pops the byte and latches the divisor for the whole frame.
  - Bit time is DIV clocks, from a down-counter loaded with DIV-1.
  - START drives 0; DATA drives 8 bits LSB first under a 3-bit counter; STOP drives 1 for one bit time.
  - With a non-empty FIFO, STOP goes straight to START, giving back-to-back frames.
  - The first start-bit clock follows the pop cycle by exactly 1 cycle.
- RX path: uart_rxd_i passes through a 2-flop synchroniser, initialised to 1.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge on the synchronised line moves to START.
  - START: after DIV/2 clocks, the line is re-sampled; 1 is treated as a glitch and returns to IDLE.
  - DATA: 8 samples, one every DIV clocks, LSB first.
  - STOP: one sample after DIV clocks.
    - Stop=0: set rx_frame_err, discard the byte, and wait in IDLE for the line to be high before accepting a new falling edge.
    - Stop=1: deliver the byte.
- Byte delivery:
  - If rx_valid=1 and no pop in this cycle: overwrite rx_data and set rx_overrun.
  - Delivery and a pop in the same cycle: load the new byte, rx_valid stays 1, no overrun.
  - A STATUS read in the same cycle as a flag set: the set wins.
- Divisor writes during a frame take effect at the next frame start, for TX and RX independently.

Decomposition:
- Package j1_io_pkg holds:
  - register offsets (REG_DATA=2'd0, REG_STATUS=2'd1, REG_DIV=2'd2);
  - STATUS bit indices;
  - the shared uart_state_t enum {IDLE, START, DATA, STOP}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides:
  - push/pop/full/empty;
  - show-ahead read data;
  - a pointer-plus-extra-bit implementation, reusable by other J1 peripherals.

Test Plan:
- DIV=4, write DATA 16'h0055 -> 1 cycle later txd low for 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; STATUS bit2 returns to 1 afterwards.
- DIV=4, 17 DATA writes with no gap (0x00..0x10) -> STATUS bit1=1 after FIFO fills; exactly 17 frames emitted (one byte already popped into the TX FSM before the FIFO filled) and the 18th write, if issued while full, is lost.
- Drive 8N1 0xA5 on rxd at DIV=8 -> rx_valid=1 and rx_irq_o=1 after the stop sample; DATA read returns 16'h00A5 in the same cycle, then rx_valid=0.
- Two frames 0x11, 0x22 without reading -> DATA reads 16'h0022; STATUS reads bit3=1, then on a second read bit3=0.
- Frame with stop bit 0 -> rx_valid unchanged, STATUS bit4=1; 1-clock low glitch on idle rxd -> no byte, no error.
- sys_rst_n_i low mid-TX-frame -> txd=1 asynchronously; after release STATUS=16'h0004 and DIVISOR reads DEFAULT_DIV; a read at an unselected address gives io_din=0.
